fmrv32im_axi_arb: RTL and testbench

//   Shares the core's single AXI4 master port (MM_AXI_*) between the I-cache refill path (read-only)
//   and the D-cache refill/writeback path (read/write). Arbitrates whole bursts with round-robin or

---
 rtl/fmrv32im_axi_arb.sv | 196 +++++++++++++++++++
 tb/tb_fmrv32im_axi_arb.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmrv32im_axi_arb.sv
// Shares one AXI4 master port between the I-cache (read-only) and D-cache (read/write) refill paths.
// Whole bursts are arbitrated (round-robin or D-priority) and then sequenced on AR/R or AW/W/B.
module fmrv32im_axi_arb #(
    parameter bit RR_EN   = 1'b1,
    parameter bit D_FIRST = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,

    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    input  logic [7:0]  I_LEN,
    input  logic        D_REQ,
    input  logic [31:0] D_ADDR,
    input  logic [7:0]  D_LEN,
    input  logic        D_WE,
    input  logic [31:0] D_WDATA,
    input  logic [3:0]  D_WSTRB,

    output logic        I_GNT,
    output logic        D_GNT,
    output logic [31:0] RDATA,
    output logic        I_RVALID,
    output logic        D_RVALID,
    output logic        D_WREADY,
    output logic        I_DONE,
    output logic        D_DONE,
    output logic        XFER_ERR,

    output logic [31:0] MM_AXI_AWADDR,
    output logic [7:0]  MM_AXI_AWLEN,
    output logic        MM_AXI_AWVALID,
    input  logic        MM_AXI_AWREADY,
    output logic [31:0] MM_AXI_WDATA,
    output logic [3:0]  MM_AXI_WSTRB,
    output logic        MM_AXI_WVALID,
    output logic        MM_AXI_WLAST,
    input  logic        MM_AXI_WREADY,
    input  logic [1:0]  MM_AXI_BRESP,
    input  logic        MM_AXI_BVALID,
    output logic        MM_AXI_BREADY,
    output logic [31:0] MM_AXI_ARADDR,
    output logic [7:0]  MM_AXI_ARLEN,
    output logic        MM_AXI_ARVALID,
    input  logic        MM_AXI_ARREADY,
    input  logic [31:0] MM_AXI_RDATA,
    input  logic [1:0]  MM_AXI_RRESP,
    input  logic        MM_AXI_RVALID,
    input  logic        MM_AXI_RLAST,
    output logic        MM_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_RD,
        S_AW,
        S_WR,
        S_B,
        S_FIN
    } state_t;

    state_t      state, state_nx;
    logic        own_d;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  cnt;
    logic        err;
    logic        rr_last;
    logic        gnt_i_q, gnt_d_q;
    logic [31:0] rdata_q;
    logic        rv_i_q, rv_d_q;

    logic        any_req;
    logic        pick_d;
    logic        last_beat;

    // rr_last names the side that finished most recently; a tie goes to the other one.
    assign any_req   = I_REQ | D_REQ;
    assign pick_d    = (I_REQ & D_REQ) ? (RR_EN ? ~rr_last : 1'b1) : D_REQ;
    assign last_beat = (cnt == len_q);

    assign I_GNT         = gnt_i_q;
    assign D_GNT         = gnt_d_q;
    assign RDATA         = rdata_q;
    assign I_RVALID      = rv_i_q;
    assign D_RVALID      = rv_d_q;
    assign MM_AXI_AWADDR = addr_q;
    assign MM_AXI_ARADDR = addr_q;
    assign MM_AXI_AWLEN  = len_q;
    assign MM_AXI_ARLEN  = len_q;
    assign MM_AXI_WDATA  = D_WDATA;
    assign MM_AXI_WSTRB  = D_WSTRB;

    always_comb begin
        state_nx       = state;
        MM_AXI_ARVALID = 1'b0;
        MM_AXI_RREADY  = 1'b0;
        MM_AXI_AWVALID = 1'b0;
        MM_AXI_WVALID  = 1'b0;
        MM_AXI_WLAST   = 1'b0;
        MM_AXI_BREADY  = 1'b0;
        I_DONE         = 1'b0;
        D_DONE         = 1'b0;
        XFER_ERR       = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) state_nx = (pick_d && D_WE) ? S_AW : S_AR;
            end
            S_AR: begin
                MM_AXI_ARVALID = 1'b1;
                if (MM_AXI_ARREADY) state_nx = S_RD;
            end
            S_RD: begin
                MM_AXI_RREADY = 1'b1;
                if (MM_AXI_RVALID && MM_AXI_RLAST) state_nx = S_FIN;
            end
            S_AW: begin
                MM_AXI_AWVALID = 1'b1;
                if (MM_AXI_AWREADY) state_nx = S_WR;
            end
            S_WR: begin
                MM_AXI_WVALID = 1'b1;
                MM_AXI_WLAST  = last_beat;
                if (MM_AXI_WREADY && last_beat) state_nx = S_B;
            end
            S_B: begin
                MM_AXI_BREADY = 1'b1;
                if (MM_AXI_BVALID) state_nx = S_FIN;
            end
            S_FIN: begin
                I_DONE   = ~own_d;
                D_DONE   = own_d;
                XFER_ERR = err;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign D_WREADY = MM_AXI_WVALID & MM_AXI_WREADY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            own_d   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            rr_last <= ~D_FIRST;
            gnt_i_q <= 1'b0;
            gnt_d_q <= 1'b0;
            rdata_q <= '0;
            rv_i_q  <= 1'b0;
            rv_d_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            gnt_i_q <= 1'b0;
            gnt_d_q <= 1'b0;
            rv_i_q  <= 1'b0;
            rv_d_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        own_d   <= pick_d;
                        addr_q  <= pick_d ? D_ADDR : I_ADDR;
                        len_q   <= pick_d ? D_LEN : I_LEN;
                        gnt_i_q <= ~pick_d;
                        gnt_d_q <= pick_d;
                    end
                end
                S_RD: begin
                    if (MM_AXI_RVALID) begin
                        rdata_q <= MM_AXI_RDATA;
                        rv_i_q  <= ~own_d;
                        rv_d_q  <= own_d;
                        if (MM_AXI_RRESP != 2'b00) err <= 1'b1;
                    end
                end
                S_WR: begin
                    if (MM_AXI_WREADY) cnt <= last_beat ? 8'd0 : cnt + 8'd1;
                end
                S_B: begin
                    if (MM_AXI_BVALID && (MM_AXI_BRESP != 2'b00)) err <= 1'b1;
                end
                S_FIN: begin
                    rr_last <= own_d;
                    err     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fmrv32im_axi_arb.sv
// Directed bench for fmrv32im_axi_arb: a scripted AXI slave plus per-scenario checking tasks.
module tb_fmrv32im_axi_arb;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N;
    logic        I_REQ, D_REQ, D_WE;
    logic [31:0] I_ADDR, D_ADDR, D_WDATA;
    logic [7:0]  I_LEN, D_LEN;
    logic [3:0]  D_WSTRB;
    logic        I_GNT, D_GNT, I_RVALID, D_RVALID, D_WREADY, I_DONE, D_DONE, XFER_ERR;
    logic [31:0] RDATA;
    logic [31:0] MM_AXI_AWADDR, MM_AXI_ARADDR, MM_AXI_WDATA, MM_AXI_RDATA;
    logic [7:0]  MM_AXI_AWLEN, MM_AXI_ARLEN;
    logic [3:0]  MM_AXI_WSTRB;
    logic        MM_AXI_AWVALID, MM_AXI_AWREADY, MM_AXI_WVALID, MM_AXI_WLAST, MM_AXI_WREADY;
    logic        MM_AXI_BVALID, MM_AXI_BREADY, MM_AXI_ARVALID, MM_AXI_ARREADY;
    logic        MM_AXI_RVALID, MM_AXI_RLAST, MM_AXI_RREADY;
    logic [1:0]  MM_AXI_BRESP, MM_AXI_RRESP;

    // second instance with fixed priority; only its grants are examined
    logic        f_rst_n, f_i_req, f_d_req;
    logic        f_i_gnt, f_d_gnt, f_i_rvalid, f_d_rvalid, f_d_wready, f_i_done, f_d_done, f_err;
    logic [31:0] f_rdata, f_awaddr, f_araddr, f_wdata;
    logic [7:0]  f_awlen, f_arlen;
    logic [3:0]  f_wstrb;
    logic        f_awvalid, f_wvalid, f_wlast, f_bready, f_arvalid, f_rready;

    fmrv32im_axi_arb #(.RR_EN(1'b1), .D_FIRST(1'b0)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_LEN(I_LEN),
        .D_REQ(D_REQ), .D_ADDR(D_ADDR), .D_LEN(D_LEN), .D_WE(D_WE),
        .D_WDATA(D_WDATA), .D_WSTRB(D_WSTRB),
        .I_GNT(I_GNT), .D_GNT(D_GNT), .RDATA(RDATA), .I_RVALID(I_RVALID), .D_RVALID(D_RVALID),
        .D_WREADY(D_WREADY), .I_DONE(I_DONE), .D_DONE(D_DONE), .XFER_ERR(XFER_ERR),
        .MM_AXI_AWADDR(MM_AXI_AWADDR), .MM_AXI_AWLEN(MM_AXI_AWLEN),
        .MM_AXI_AWVALID(MM_AXI_AWVALID), .MM_AXI_AWREADY(MM_AXI_AWREADY),
        .MM_AXI_WDATA(MM_AXI_WDATA), .MM_AXI_WSTRB(MM_AXI_WSTRB), .MM_AXI_WVALID(MM_AXI_WVALID),
        .MM_AXI_WLAST(MM_AXI_WLAST), .MM_AXI_WREADY(MM_AXI_WREADY),
        .MM_AXI_BRESP(MM_AXI_BRESP), .MM_AXI_BVALID(MM_AXI_BVALID), .MM_AXI_BREADY(MM_AXI_BREADY),
        .MM_AXI_ARADDR(MM_AXI_ARADDR), .MM_AXI_ARLEN(MM_AXI_ARLEN),
        .MM_AXI_ARVALID(MM_AXI_ARVALID), .MM_AXI_ARREADY(MM_AXI_ARREADY),
        .MM_AXI_RDATA(MM_AXI_RDATA), .MM_AXI_RRESP(MM_AXI_RRESP), .MM_AXI_RVALID(MM_AXI_RVALID),
        .MM_AXI_RLAST(MM_AXI_RLAST), .MM_AXI_RREADY(MM_AXI_RREADY)
    );

    fmrv32im_axi_arb #(.RR_EN(1'b0), .D_FIRST(1'b0)) u_fix (
        .CLK(CLK), .RST_N(f_rst_n),
        .I_REQ(f_i_req), .I_ADDR(I_ADDR), .I_LEN(I_LEN),
        .D_REQ(f_d_req), .D_ADDR(D_ADDR), .D_LEN(D_LEN), .D_WE(D_WE),
        .D_WDATA(D_WDATA), .D_WSTRB(D_WSTRB),
        .I_GNT(f_i_gnt), .D_GNT(f_d_gnt), .RDATA(f_rdata), .I_RVALID(f_i_rvalid), .D_RVALID(f_d_rvalid),
        .D_WREADY(f_d_wready), .I_DONE(f_i_done), .D_DONE(f_d_done), .XFER_ERR(f_err),
        .MM_AXI_AWADDR(f_awaddr), .MM_AXI_AWLEN(f_awlen),
        .MM_AXI_AWVALID(f_awvalid), .MM_AXI_AWREADY(MM_AXI_AWREADY),
        .MM_AXI_WDATA(f_wdata), .MM_AXI_WSTRB(f_wstrb), .MM_AXI_WVALID(f_wvalid),
        .MM_AXI_WLAST(f_wlast), .MM_AXI_WREADY(MM_AXI_WREADY),
        .MM_AXI_BRESP(MM_AXI_BRESP), .MM_AXI_BVALID(MM_AXI_BVALID), .MM_AXI_BREADY(f_bready),
        .MM_AXI_ARADDR(f_araddr), .MM_AXI_ARLEN(f_arlen),
        .MM_AXI_ARVALID(f_arvalid), .MM_AXI_ARREADY(MM_AXI_ARREADY),
        .MM_AXI_RDATA(MM_AXI_RDATA), .MM_AXI_RRESP(MM_AXI_RRESP), .MM_AXI_RVALID(MM_AXI_RVALID),
        .MM_AXI_RLAST(MM_AXI_RLAST), .MM_AXI_RREADY(f_rready)
    );

    logic [161:0] all_out;
    assign all_out = {I_GNT, D_GNT, RDATA, I_RVALID, D_RVALID, D_WREADY, I_DONE, D_DONE, XFER_ERR,
                      MM_AXI_AWADDR, MM_AXI_ARADDR, MM_AXI_AWLEN, MM_AXI_ARLEN,
                      MM_AXI_AWVALID, MM_AXI_ARVALID, MM_AXI_WDATA, MM_AXI_WSTRB,
                      MM_AXI_WVALID, MM_AXI_WLAST, MM_AXI_BREADY, MM_AXI_RREADY};

    int n_cmp = 0;
    int n_bad = 0;

    // event counters sampled on the falling edge, away from the active edge
    int          i_rv = 0, d_rv = 0, i_done = 0, d_done = 0, d_wr = 0, wlast_n = 0, wlast_at = 0;
    logic        last_i_err = 1'b0, last_d_err = 1'b0;
    logic [31:0] last_i_rdata = '0;

    always @(negedge CLK) begin
        if (I_RVALID) begin
            i_rv         <= i_rv + 1;
            last_i_rdata <= RDATA;
        end
        if (D_RVALID) d_rv <= d_rv + 1;
        if (I_DONE) begin
            i_done     <= i_done + 1;
            last_i_err <= XFER_ERR;
        end
        if (D_DONE) begin
            d_done     <= d_done + 1;
            last_d_err <= XFER_ERR;
        end
        if (D_WREADY) d_wr <= d_wr + 1;
        if (MM_AXI_WVALID && MM_AXI_WREADY && MM_AXI_WLAST) begin
            wlast_n  <= wlast_n + 1;
            wlast_at <= d_wr + 1;
        end
    end

    logic [31:0] obs_addr;
    logic [7:0]  obs_len;
    logic [31:0] obs_wdata;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_gnt(input bit side);
        int t = 0;
        do begin
            tick();
            t++;
        end while (!(side ? D_GNT : I_GNT) && t < 20);
        if (!(side ? D_GNT : I_GNT)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL gnt_timeout side=%0d got=0 exp=1", side);
        end
        if (side) D_REQ = 1'b0;
        else      I_REQ = 1'b0;
    endtask

    task automatic issue(input bit side, input logic [31:0] addr, input logic [7:0] len, input logic we);
        if (side) begin
            D_REQ = 1'b1; D_ADDR = addr; D_LEN = len; D_WE = we;
        end else begin
            I_REQ = 1'b1; I_ADDR = addr; I_LEN = len;
        end
        wait_gnt(side);
    endtask

    task automatic slave_read(input int ar_wait, input int nbeats, input int err_beat, input logic [31:0] base);
        int t = 0;
        bit acc;
        while (!MM_AXI_ARVALID && t < 50) begin
            tick();
            t++;
        end
        if (!MM_AXI_ARVALID) begin
            n_cmp++;
            n_bad++;
            $display("FAIL arvalid_timeout got=0 exp=1");
            return;
        end
        repeat (ar_wait) tick();
        obs_addr = MM_AXI_ARADDR;
        obs_len  = MM_AXI_ARLEN;
        MM_AXI_ARREADY = 1'b1;
        tick();
        MM_AXI_ARREADY = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            MM_AXI_RVALID = 1'b1;
            MM_AXI_RDATA  = base + 32'(b);
            MM_AXI_RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
            MM_AXI_RLAST  = (b == nbeats - 1);
            t = 0;
            do begin
                acc = MM_AXI_RREADY;
                tick();
                t++;
            end while (!acc && t < 50);
        end
        MM_AXI_RVALID = 1'b0;
        MM_AXI_RLAST  = 1'b0;
        MM_AXI_RRESP  = 2'b00;
    endtask

    task automatic slave_write(input bit toggle, input logic [1:0] bresp);
        int  t = 0;
        bit  done = 0, ph = 0, acc;
        while (!MM_AXI_AWVALID && t < 50) begin
            tick();
            t++;
        end
        obs_addr = MM_AXI_AWADDR;
        obs_len  = MM_AXI_AWLEN;
        MM_AXI_AWREADY = 1'b1;
        tick();
        MM_AXI_AWREADY = 1'b0;
        t = 0;
        while (!done && t < 2000) begin
            MM_AXI_WREADY = toggle ? ph : 1'b1;
            ph = ~ph;
            if (MM_AXI_WVALID && MM_AXI_WREADY) obs_wdata = MM_AXI_WDATA;
            done = MM_AXI_WVALID && MM_AXI_WREADY && MM_AXI_WLAST;
            tick();
            t++;
        end
        MM_AXI_WREADY = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wlast_timeout got=0 exp=1");
        end
        MM_AXI_BVALID = 1'b1;
        MM_AXI_BRESP  = bresp;
        t = 0;
        do begin
            acc = MM_AXI_BREADY;
            tick();
            t++;
        end while (!acc && t < 50);
        MM_AXI_BVALID = 1'b0;
        MM_AXI_BRESP  = 2'b00;
    endtask

    // both sides request together; reports which side was granted first and second
    task automatic race(output int first, output int second);
        int t = 0;
        I_REQ = 1'b1; I_ADDR = 32'h200; I_LEN = 8'd0;
        D_REQ = 1'b1; D_ADDR = 32'h300; D_LEN = 8'd0; D_WE = 1'b0;
        do begin tick(); t++; end while (!I_GNT && !D_GNT && t < 20);
        first = D_GNT ? 1 : (I_GNT ? 0 : -1);
        if (first == 1) D_REQ = 1'b0;
        else            I_REQ = 1'b0;
        if (first < 0) begin
            D_REQ  = 1'b0;
            second = -1;
            return;
        end
        slave_read(0, 1, -1, 32'hB000);
        t = 0;
        do begin tick(); t++; end while (!I_GNT && !D_GNT && t < 20);
        second = D_GNT ? 1 : (I_GNT ? 0 : -1);
        I_REQ = 1'b0;
        D_REQ = 1'b0;
        if (second >= 0) slave_read(0, 1, -1, 32'hB100);
        repeat (2) tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
        RST_N = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (all_out !== '0) begin n_bad++; $display("FAIL idle_outputs got=%h exp=0", all_out); end
    endtask

    task automatic test_i_read();
        int s_irv = i_rv, s_drv = d_rv, s_done = i_done;
        issue(1'b0, 32'h100, 8'd3, 1'b0);
        slave_read(2, 4, -1, 32'hA000);
        repeat (3) tick();
        n_cmp++;
        if (obs_addr !== 32'h100) begin n_bad++; $display("FAIL i_read_araddr got=%h exp=%h", obs_addr, 32'h100); end
        n_cmp++;
        if (obs_len !== 8'd3) begin n_bad++; $display("FAIL i_read_arlen got=%0d exp=3", obs_len); end
        n_cmp++;
        if (i_rv - s_irv != 4) begin n_bad++; $display("FAIL i_read_beats got=%0d exp=4", i_rv - s_irv); end
        n_cmp++;
        if (d_rv - s_drv != 0) begin n_bad++; $display("FAIL i_read_d_rvalid got=%0d exp=0", d_rv - s_drv); end
        n_cmp++;
        if (i_done - s_done != 1) begin n_bad++; $display("FAIL i_read_done got=%0d exp=1", i_done - s_done); end
        n_cmp++;
        if (last_i_err !== 1'b0) begin n_bad++; $display("FAIL i_read_err got=%b exp=0", last_i_err); end
        n_cmp++;
        if (last_i_rdata !== 32'hA003) begin n_bad++; $display("FAIL i_read_rdata got=%h exp=%h", last_i_rdata, 32'hA003); end
    endtask

    task automatic test_d_write_single();
        int s_wr = d_wr, s_wl = wlast_n, s_done = d_done, s_drv = d_rv;
        D_WDATA = 32'hDEADBEEF;
        D_WSTRB = 4'hF;
        issue(1'b1, 32'h800, 8'd0, 1'b1);
        slave_write(1'b0, 2'b00);
        repeat (3) tick();
        n_cmp++;
        if (obs_addr !== 32'h800) begin n_bad++; $display("FAIL d_wr_awaddr got=%h exp=%h", obs_addr, 32'h800); end
        n_cmp++;
        if (obs_len !== 8'd0) begin n_bad++; $display("FAIL d_wr_awlen got=%0d exp=0", obs_len); end
        n_cmp++;
        if (obs_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL d_wr_wdata got=%h exp=deadbeef", obs_wdata); end
        n_cmp++;
        if (d_wr - s_wr != 1) begin n_bad++; $display("FAIL d_wr_beats got=%0d exp=1", d_wr - s_wr); end
        n_cmp++;
        if (wlast_n - s_wl != 1 || wlast_at - s_wr != 1) begin
            n_bad++; $display("FAIL d_wr_wlast count=%0d at=%0d exp=1/1", wlast_n - s_wl, wlast_at - s_wr);
        end
        n_cmp++;
        if (d_done - s_done != 1) begin n_bad++; $display("FAIL d_wr_done got=%0d exp=1", d_done - s_done); end
        n_cmp++;
        if (d_rv - s_drv != 0) begin n_bad++; $display("FAIL d_wr_rvalid got=%0d exp=0", d_rv - s_drv); end
        n_cmp++;
        if (last_d_err !== 1'b0) begin n_bad++; $display("FAIL d_wr_err got=%b exp=0", last_d_err); end
        D_WDATA = '0;
        D_WSTRB = '0;
        D_WE    = 1'b0;
    endtask

    task automatic test_round_robin();
        int f1, s1, f2, s2;
        int s_drv = d_rv;
        race(f1, s1);
        race(f2, s2);
        n_cmp++;
        if (f1 != 0) begin n_bad++; $display("FAIL rr_tie1_first got=%0d exp=0", f1); end
        n_cmp++;
        if (s1 != 1) begin n_bad++; $display("FAIL rr_tie1_second got=%0d exp=1", s1); end
        n_cmp++;
        if (f2 != 0) begin n_bad++; $display("FAIL rr_tie2_first got=%0d exp=0", f2); end
        n_cmp++;
        if (d_rv - s_drv != 2) begin n_bad++; $display("FAIL rr_d_beats got=%0d exp=2", d_rv - s_drv); end
    endtask

    task automatic test_fixed_priority();
        for (int r = 0; r < 2; r++) begin
            f_rst_n = 1'b0;
            repeat (2) tick();
            f_rst_n = 1'b1;
            f_i_req = 1'b1;
            f_d_req = 1'b1;
            tick();
            n_cmp++;
            if ({f_i_gnt, f_d_gnt} !== 2'b01) begin
                n_bad++; $display("FAIL fixed_tie%0d got I=%b D=%b exp I=0 D=1", r, f_i_gnt, f_d_gnt);
            end
            f_i_req = 1'b0;
            f_d_req = 1'b0;
        end
        f_rst_n = 1'b0;
    endtask

    task automatic test_long_write();
        int s_wr = d_wr, s_wl = wlast_n, s_done = d_done;
        D_WSTRB = 4'hF;
        issue(1'b1, 32'h1000, 8'd255, 1'b1);
        slave_write(1'b1, 2'b00);
        repeat (4) tick();
        n_cmp++;
        if (obs_len !== 8'd255) begin n_bad++; $display("FAIL long_awlen got=%0d exp=255", obs_len); end
        n_cmp++;
        if (d_wr - s_wr != 256) begin n_bad++; $display("FAIL long_beats got=%0d exp=256", d_wr - s_wr); end
        n_cmp++;
        if (wlast_n - s_wl != 1) begin n_bad++; $display("FAIL long_wlast_count got=%0d exp=1", wlast_n - s_wl); end
        n_cmp++;
        if (wlast_at - s_wr != 256) begin n_bad++; $display("FAIL long_wlast_beat got=%0d exp=256", wlast_at - s_wr); end
        n_cmp++;
        if (d_done - s_done != 1 || last_d_err !== 1'b0) begin
            n_bad++; $display("FAIL long_done got=%0d err=%b exp=1 err=0", d_done - s_done, last_d_err);
        end
        D_WSTRB = '0;
        D_WE    = 1'b0;
    endtask

    task automatic test_rresp_err();
        int s_irv = i_rv, s_done = i_done;
        issue(1'b0, 32'h400, 8'd3, 1'b0);
        slave_read(0, 4, 1, 32'hC000);
        repeat (3) tick();
        n_cmp++;
        if (i_rv - s_irv != 4) begin n_bad++; $display("FAIL err_beats got=%0d exp=4", i_rv - s_irv); end
        n_cmp++;
        if (i_done - s_done != 1 || last_i_err !== 1'b1) begin
            n_bad++; $display("FAIL err_flag done=%0d err=%b exp=1 err=1", i_done - s_done, last_i_err);
        end
        issue(1'b0, 32'h500, 8'd1, 1'b0);
        slave_read(1, 2, -1, 32'hC100);
        repeat (3) tick();
        n_cmp++;
        if (i_done - s_done != 2 || last_i_err !== 1'b0) begin
            n_bad++; $display("FAIL err_cleared done=%0d err=%b exp=2 err=0", i_done - s_done, last_i_err);
        end
    endtask

    task automatic test_reset_mid();
        int s_done = i_done;
        issue(1'b0, 32'h600, 8'd3, 1'b0);
        MM_AXI_ARREADY = 1'b1;
        tick();
        MM_AXI_ARREADY = 1'b0;
        MM_AXI_RVALID  = 1'b1;
        MM_AXI_RDATA   = 32'h1;
        tick();
        MM_AXI_RDATA = 32'h2;
        RST_N = 1'b0;
        tick();
        MM_AXI_RVALID = 1'b0;
        MM_AXI_RDATA  = '0;
        n_cmp++;
        if (all_out !== '0) begin n_bad++; $display("FAIL midreset_outputs got=%h exp=0", all_out); end
        RST_N = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (i_done - s_done != 0) begin n_bad++; $display("FAIL midreset_no_done got=%0d exp=0", i_done - s_done); end
        issue(1'b0, 32'h700, 8'd0, 1'b0);
        slave_read(0, 1, -1, 32'hD000);
        repeat (2) tick();
        n_cmp++;
        if (i_done - s_done != 1 || obs_addr !== 32'h700) begin
            n_bad++; $display("FAIL midreset_regrant done=%0d addr=%h exp=1 addr=700", i_done - s_done, obs_addr);
        end
    endtask

    initial begin
        RST_N = 1'b0; f_rst_n = 1'b0; f_i_req = 1'b0; f_d_req = 1'b0;
        I_REQ = 1'b0; I_ADDR = '0; I_LEN = '0;
        D_REQ = 1'b0; D_ADDR = '0; D_LEN = '0; D_WE = 1'b0; D_WDATA = '0; D_WSTRB = '0;
        MM_AXI_AWREADY = 1'b0; MM_AXI_WREADY = 1'b0; MM_AXI_BVALID = 1'b0; MM_AXI_BRESP = 2'b00;
        MM_AXI_ARREADY = 1'b0; MM_AXI_RVALID = 1'b0; MM_AXI_RLAST = 1'b0; MM_AXI_RRESP = 2'b00;
        MM_AXI_RDATA = '0;
        test_reset();
        test_i_read();
        test_d_write_single();
        test_round_robin();
        test_fixed_priority();
        test_long_write();
        test_rresp_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
